// File: rtl/i2c_pkg.sv
// Shared I2C definitions: bus FSM states, field widths and R/W bit position.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_BYTE_W = 8;
    localparam int I2C_RW_BIT = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_WAIT
    } i2c_state_e;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-stage synchroniser for one bus line with registered rise/fall strobes.
// level_o is the value the strobes refer to, so all three stay cycle-aligned.
module i2c_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic n_rst,
    input  logic din_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise_q;
    logic                   fall_q;

    // Reset to the idle-high bus level so releasing reset never fakes an edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
            prev_q <= sync_q[SYNC_STAGES-1];
            rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
            fall_q <= ~sync_q[SYNC_STAGES-1] & prev_q;
        end
    end

    assign level_o = prev_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_slave_rx.sv
// Oversampling I2C target endpoint: START/STOP detect, address match, ACK, write and read bytes.
// Define I2C_SLAVE_READ_EN to build the read path; otherwise read addressing is NACKed.
module i2c_slave_rx
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] ADDR        = 7'h54,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  scl,
    input  logic                  sda_in,
    output logic                  sda_oe,
    output logic [I2C_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    input  logic [I2C_BYTE_W-1:0] tx_data,
    output logic                  tx_req,
    output logic                  busy,
    output logic                  stop_det
);

    logic [1:0] line_in;
    logic [1:0] line_lvl;
    logic [1:0] line_rise;
    logic [1:0] line_fall;

    assign line_in = {sda_in, scl};

    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
        i2c_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk    (clk),
            .n_rst  (n_rst),
            .din_i  (line_in[gi]),
            .level_o(line_lvl[gi]),
            .rise_o (line_rise[gi]),
            .fall_o (line_fall[gi])
        );
    end

    logic scl_lvl, scl_rise, scl_fall, sda_lvl, start_ev, stop_ev;
    assign scl_lvl  = line_lvl[0];
    assign scl_rise = line_rise[0];
    assign scl_fall = line_fall[0];
    assign sda_lvl  = line_lvl[1];
    assign start_ev = line_fall[1] & scl_lvl;
    assign stop_ev  = line_rise[1] & scl_lvl;

    i2c_state_e            state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [I2C_BYTE_W-1:0] shift_q, shift_d;
    logic                  byte_done_q, byte_done_d;
    logic                  ack_q, ack_d;
    logic                  rw_q, rw_d;
    logic                  sda_oe_q, sda_oe_d;
    logic [I2C_BYTE_W-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  busy_q, busy_d;
    logic                  stop_det_q, stop_det_d;
`ifdef I2C_SLAVE_READ_EN
    logic [I2C_BYTE_W-1:0] tx_shift_q, tx_shift_d;
    logic                  tx_req_q, tx_req_d;
`else
    logic                  tx_unused;
    assign tx_unused = ^tx_data;
`endif

    // Byte as it stands once the bit being sampled this cycle is shifted in.
    logic [I2C_BYTE_W-1:0] byte_w;
    logic                  addr_hit;
    logic                  last_bit;
    assign byte_w   = {shift_q[I2C_BYTE_W-2:0], sda_lvl};
    assign addr_hit = (byte_w[I2C_BYTE_W-1 -: I2C_ADDR_W] == ADDR);
    assign last_bit = (bit_cnt_q == 3'd7);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        byte_done_d = byte_done_q;
        ack_d       = ack_q;
        rw_d        = rw_q;
        sda_oe_d    = sda_oe_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        busy_d      = busy_q;
        stop_det_d  = 1'b0;
`ifdef I2C_SLAVE_READ_EN
        tx_shift_d  = tx_shift_q;
        tx_req_d    = 1'b0;
`endif
        if (stop_ev) begin
            state_d     = ST_IDLE;
            bit_cnt_d   = 3'd0;
            byte_done_d = 1'b0;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b0;
            stop_det_d  = 1'b1;
        end else if (start_ev) begin
            state_d     = ST_ADDR;
            bit_cnt_d   = 3'd0;
            byte_done_d = 1'b0;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = byte_w;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit) begin
                            rw_d = byte_w[I2C_RW_BIT];
                            if (!addr_hit) begin
                                state_d = ST_WAIT;
                            end else begin
`ifdef I2C_SLAVE_READ_EN
                                byte_done_d = 1'b1;
                                tx_req_d    = byte_w[I2C_RW_BIT];
`else
                                if (byte_w[I2C_RW_BIT]) state_d = ST_WAIT;
                                else                    byte_done_d = 1'b1;
`endif
                            end
                        end
                    end else if (scl_fall && byte_done_q) begin
                        byte_done_d = 1'b0;
                        state_d     = ST_ADDR_ACK;
                        sda_oe_d    = 1'b1;
                        busy_d      = 1'b1;
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 3'd0;
                        if (!rw_q) begin
                            state_d = ST_WR_DATA;
                        end else begin
`ifdef I2C_SLAVE_READ_EN
                            state_d    = ST_RD_DATA;
                            tx_shift_d = tx_data;
                            sda_oe_d   = ~tx_data[I2C_BYTE_W-1];
`else
                            state_d = ST_WAIT;
`endif
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (scl_rise) begin
                        shift_d   = byte_w;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit) begin
                            byte_done_d = 1'b1;
                            ack_d       = rx_ready;
                            if (rx_ready) begin
                                rx_data_d  = byte_w;
                                rx_valid_d = 1'b1;
                            end
                        end
                    end else if (scl_fall && byte_done_q) begin
                        byte_done_d = 1'b0;
                        state_d     = ST_WR_ACK;
                        sda_oe_d    = ack_q;
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 3'd0;
                        state_d   = ack_q ? ST_WR_DATA : ST_WAIT;
                    end
                end
`ifdef I2C_SLAVE_READ_EN
                ST_RD_DATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit) byte_done_d = 1'b1;
                    end else if (scl_fall) begin
                        if (byte_done_q) begin
                            byte_done_d = 1'b0;
                            sda_oe_d    = 1'b0;
                            ack_d       = 1'b0;
                            state_d     = ST_RD_ACK;
                        end else begin
                            tx_shift_d = tx_shift_q << 1;
                            sda_oe_d   = ~tx_shift_q[I2C_BYTE_W-2];
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_lvl) begin
                            tx_req_d = 1'b1;
                            ack_d    = 1'b1;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end else if (scl_fall && ack_q) begin
                        ack_d      = 1'b0;
                        bit_cnt_d  = 3'd0;
                        state_d    = ST_RD_DATA;
                        tx_shift_d = tx_data;
                        sda_oe_d   = ~tx_data[I2C_BYTE_W-1];
                    end
                end
`endif
                default: begin
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= '0;
            byte_done_q <= 1'b0;
            ack_q       <= 1'b0;
            rw_q        <= 1'b0;
            sda_oe_q    <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            stop_det_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            byte_done_q <= byte_done_d;
            ack_q       <= ack_d;
            rw_q        <= rw_d;
            sda_oe_q    <= sda_oe_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            busy_q      <= busy_d;
            stop_det_q  <= stop_det_d;
        end
    end

`ifdef I2C_SLAVE_READ_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tx_shift_q <= '0;
            tx_req_q   <= 1'b0;
        end else begin
            tx_shift_q <= tx_shift_d;
            tx_req_q   <= tx_req_d;
        end
    end
    assign tx_req = tx_req_q;
`else
    assign tx_req = 1'b0;
`endif

    assign sda_oe   = sda_oe_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
    assign stop_det = stop_det_q;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Directed bench for i2c_slave_rx: a bit-level master drives the bus, a scoreboard checks strobes.
module tb_i2c_slave_rx;

    localparam int EV_RX   = 0;
    localparam int EV_TXRQ = 1;
    localparam int EV_STOP = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       scl;
    logic       m_sda;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       busy;
    logic       stop_det;

    int  total = 0;
    int  bad = 0;
    int  nodrive_hits = 0;
    bit  chk_nodrive = 1'b0;
    ev_t exp_q[$];

    assign sda_line = m_sda & ~sda_oe;

    always #5 clk = ~clk;

    i2c_slave_rx #(
        .ADDR       (7'h54),
        .SYNC_STAGES(2)
    ) dut (
        .clk     (clk),
        .n_rst   (n_rst),
        .scl     (scl),
        .sda_in  (sda_line),
        .sda_oe  (sda_oe),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .tx_data (tx_data),
        .tx_req  (tx_req),
        .busy    (busy),
        .stop_det(stop_det)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_ev(input int kind, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every strobe must match the oldest expected event.
    always @(negedge clk) begin
        logic [2:0] vec;
        logic [2:0] want;
        ev_t        e;
        vec = {rx_valid, tx_req, stop_det};
        if (chk_nodrive && sda_oe) nodrive_hits++;
        if (vec != 3'b000) begin
            if (exp_q.size() == 0) begin
                check("spurious strobe", {29'd0, vec}, 32'd0);
            end else begin
                e    = exp_q.pop_front();
                want = 3'b100 >> e.kind;
                check("strobe kind", {29'd0, vec}, {29'd0, want});
                if (e.kind == EV_RX) check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
                $display("txn: strobe %b data %h", vec, rx_data);
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // One SCL period: data set mid-low, sampled mid-high.
    task automatic clock_bit(input logic b, output logic line_s, output logic oe_s);
        wait_clk(3);
        m_sda = b;
        wait_clk(7);
        scl = 1'b1;
        wait_clk(5);
        line_s = sda_line;
        oe_s   = sda_oe;
        wait_clk(5);
        scl = 1'b0;
    endtask

    task automatic i2c_start();
        wait_clk(3);
        m_sda = 1'b1;
        wait_clk(7);
        scl = 1'b1;
        wait_clk(10);
        m_sda = 1'b0;
        wait_clk(10);
        scl = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clk(3);
        m_sda = 1'b0;
        wait_clk(7);
        scl = 1'b1;
        wait_clk(10);
        m_sda = 1'b1;
        wait_clk(10);
    endtask

    task automatic wr_byte(input logic [7:0] b, input logic exp_ack);
        logic l, o;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], l, o);
        clock_bit(1'b1, l, o);
        check($sformatf("ack after %h", b), {31'd0, o}, {31'd0, exp_ack});
        $display("txn: wrote %h ack=%b", b, o);
    endtask

    task automatic rd_byte(input logic [7:0] exp, input logic master_ack);
        logic       l, o;
        logic [7:0] got;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, l, o);
            got[i] = l;
        end
        check("read byte", {24'd0, got}, {24'd0, exp});
        clock_bit(~master_ack, l, o);
        check("sda released at master ack", {31'd0, o}, 32'd0);
        $display("txn: read %h", got);
    endtask

    initial begin
        logic       l, o;
        logic [7:0] b;
        n_rst    = 1'b0;
        scl      = 1'b1;
        m_sda    = 1'b1;
        rx_ready = 1'b1;
        tx_data  = 8'h00;
        wait_clk(5);
        check("reset sda_oe", {31'd0, sda_oe}, 32'd0);
        check("reset rx_data", {24'd0, rx_data}, 32'd0);
        check("reset rx_valid", {31'd0, rx_valid}, 32'd0);
        check("reset tx_req", {31'd0, tx_req}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset stop_det", {31'd0, stop_det}, 32'd0);
        n_rst = 1'b1;
        wait_clk(5);

        // Plain write of one byte
        push_ev(EV_RX, 8'h3C);
        push_ev(EV_STOP, 8'h00);
        i2c_start();
        wr_byte(8'hA8, 1'b1);
        check("busy after match", {31'd0, busy}, 32'd1);
        wr_byte(8'h3C, 1'b1);
        i2c_stop();
        check("busy after stop", {31'd0, busy}, 32'd0);
        check("rx_data write", {24'd0, rx_data}, 32'h3C);

        // Wrong address: never driven, further bytes ignored
        nodrive_hits = 0;
        chk_nodrive  = 1'b1;
        push_ev(EV_STOP, 8'h00);
        i2c_start();
        wr_byte(8'hAA, 1'b0);
        wr_byte(8'h55, 1'b0);
        check("busy wrong addr", {31'd0, busy}, 32'd0);
        i2c_stop();
        chk_nodrive = 1'b0;
        check("wrong addr drive cycles", nodrive_hits, 32'd0);

        // Read request
`ifdef I2C_SLAVE_READ_EN
        tx_data = 8'hB5;
        push_ev(EV_TXRQ, 8'h00);
        push_ev(EV_STOP, 8'h00);
        i2c_start();
        wr_byte(8'hA9, 1'b1);
        rd_byte(8'hB5, 1'b0);
        nodrive_hits = 0;
        chk_nodrive  = 1'b1;
        wr_byte(8'hFF, 1'b0);
        chk_nodrive = 1'b0;
        check("read wait drive cycles", nodrive_hits, 32'd0);
        i2c_stop();
`else
        tx_data = 8'hB5;
        push_ev(EV_STOP, 8'h00);
        i2c_start();
        wr_byte(8'hA9, 1'b0);
        i2c_stop();
`endif

        // Back-pressure: byte NACKed, no strobe
        rx_ready = 1'b0;
        push_ev(EV_STOP, 8'h00);
        i2c_start();
        wr_byte(8'hA8, 1'b1);
        wr_byte(8'h77, 1'b0);
        i2c_stop();
        rx_ready = 1'b1;
        check("rx_data kept on nack", {24'd0, rx_data}, 32'h3C);

        // Repeated START after a partial byte
        push_ev(EV_RX, 8'h01);
        push_ev(EV_STOP, 8'h00);
        i2c_start();
        wr_byte(8'hA8, 1'b1);
        b = 8'hA0;
        for (int i = 7; i >= 4; i--) clock_bit(b[i], l, o);
        i2c_start();
        wr_byte(8'hA8, 1'b1);
        wr_byte(8'h01, 1'b1);
        i2c_stop();
        check("rx_data after resync", {24'd0, rx_data}, 32'h01);

        // Reset asserted while the address ACK is being driven
        i2c_start();
        b = 8'hA8;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], l, o);
        wait_clk(8);
        check("sda_oe in addr ack", {31'd0, sda_oe}, 32'd1);
        #3;
        n_rst = 1'b0;
        #1;
        check("sda_oe async reset", {31'd0, sda_oe}, 32'd0);
        check("busy in reset", {31'd0, busy}, 32'd0);
        check("rx_data in reset", {24'd0, rx_data}, 32'd0);
        check("rx_valid in reset", {31'd0, rx_valid}, 32'd0);
        check("tx_req in reset", {31'd0, tx_req}, 32'd0);
        check("stop_det in reset", {31'd0, stop_det}, 32'd0);
        wait_clk(3);
        scl = 1'b1;
        wait_clk(3);
        m_sda = 1'b1;
        wait_clk(3);
        n_rst = 1'b1;
        wait_clk(10);

        check("events outstanding", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
